bmp_param_dp_ram: RTL and testbench

BMP_PARAM_DP_RAM -- requirements
Module: bmp_param_dp_ram

---
 rtl/bmp_param_dp_ram_pkg.sv | 37 +++
 rtl/bmp_rd_pipe.sv | 106 ++++++++++
 rtl/bmp_param_dp_ram.sv | 197 +++++++++++++++++++
 tb/tb_bmp_param_dp_ram.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bmp_param_dp_ram_pkg.sv
// ---------------------------------------------------------------------------
// bmp_param_dp_ram_pkg
// Shared definitions for the dual-port BMP pixel/byte RAM:
//   - default geometry macros (normally supplied by DEFINE.vh; the guarded
//     fallbacks below are used only when that header has not been seen)
//   - clear-engine state codes and state type
//   - small helpers used by the top level
// ---------------------------------------------------------------------------
`ifndef BYTE_WIDTH
`define BYTE_WIDTH 8
`endif
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 5
`endif
`ifndef BMP_TOTAL_SIZE
`define BMP_TOTAL_SIZE 16
`endif

package bmp_param_dp_ram_pkg;

   // Clear-engine state codes.
   localparam logic ST_IDLE_CODE  = 1'b0;
   localparam logic ST_CLEAR_CODE = 1'b1;

   typedef enum logic {
      ST_IDLE  = ST_IDLE_CODE,
      ST_CLEAR = ST_CLEAR_CODE
   } clr_state_e;

   localparam int NUM_PORTS = 2;

   // Index of the opposite port, used for cross-port read-during-write.
   function automatic int other_port(input int p);
      return (p == 0) ? 1 : 0;
   endfunction

endpackage

// File: rtl/bmp_rd_pipe.sv
// ---------------------------------------------------------------------------
// bmp_rd_pipe
// Per-port read-return pipeline. Tracks accepted reads, delays them to the
// configured latency, forces rdata to zero whenever rvalid is low or the
// read was out of range, and merges the write out-of-range pulse into oob.
//
// Ports:
//   clk       in   clock
//   rst       in   synchronous active-high reset (flushes the pipeline)
//   rd_acc    in   read accepted this cycle
//   rd_oob    in   accepted read address is out of range
//   wr_oob    in   accepted write address is out of range
//   ram_word  in   registered RAM word, valid the cycle after rd_acc
//   rvalid    out  rdata qualifier
//   rdata     out  read data (zero when rvalid is low)
//   oob       out  out-of-range flag (read: in rvalid cycle; write: +1 cycle)
// ---------------------------------------------------------------------------
module bmp_rd_pipe
   import bmp_param_dp_ram_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int RD_LATENCY = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  rd_acc,
   input  logic                  rd_oob,
   input  logic                  wr_oob,
   input  logic [DATA_WIDTH-1:0] ram_word,
   output logic                  rvalid,
   output logic [DATA_WIDTH-1:0] rdata,
   output logic                  oob
);

   logic                  s1_vld_q, s1_vld_d;
   logic                  s1_oob_q, s1_oob_d;
   logic                  wr_oob_q, wr_oob_d;
   logic [DATA_WIDTH-1:0] s1_data;

   logic                  out_vld;
   logic                  out_oob;
   logic [DATA_WIDTH-1:0] out_data;

   always_comb begin
      s1_vld_d = rd_acc;
      s1_oob_d = rd_acc & rd_oob;
      wr_oob_d = wr_oob;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_vld_q <= 1'b0;
         s1_oob_q <= 1'b0;
         wr_oob_q <= 1'b0;
      end else begin
         s1_vld_q <= s1_vld_d;
         s1_oob_q <= s1_oob_d;
         wr_oob_q <= wr_oob_d;
      end
   end

   // The RAM word register sits in the parent; zero it here for idle or
   // out-of-range returns so the data path never leaks aliased contents.
   assign s1_data = (s1_vld_q && !s1_oob_q) ? ram_word : '0;

   generate
      if (RD_LATENCY == 2) begin : g_lat2
         logic                  s2_vld_q, s2_vld_d;
         logic                  s2_oob_q, s2_oob_d;
         logic [DATA_WIDTH-1:0] s2_data_q, s2_data_d;

         always_comb begin
            s2_vld_d  = s1_vld_q;
            s2_oob_d  = s1_oob_q;
            s2_data_d = s1_data;
         end

         always_ff @(posedge clk) begin
            if (rst) begin
               s2_vld_q  <= 1'b0;
               s2_oob_q  <= 1'b0;
               s2_data_q <= '0;
            end else begin
               s2_vld_q  <= s2_vld_d;
               s2_oob_q  <= s2_oob_d;
               s2_data_q <= s2_data_d;
            end
         end

         assign out_vld  = s2_vld_q;
         assign out_oob  = s2_oob_q;
         assign out_data = s2_data_q;
      end else begin : g_lat1
         assign out_vld  = s1_vld_q;
         assign out_oob  = s1_oob_q;
         assign out_data = s1_data;
      end
   endgenerate

   // Outputs are held quiet for the whole reset interval, not just after
   // the first reset edge.
   assign rvalid = out_vld & ~rst;
   assign oob    = (out_oob | wr_oob_q) & ~rst;
   assign rdata  = rst ? '0 : out_data;

endmodule

// File: rtl/bmp_param_dp_ram.sv
// ---------------------------------------------------------------------------
// bmp_param_dp_ram
// True dual-port RAM for BMP pixel/byte storage with a built-in clear
// engine. Each port accepts one read or one write per cycle while the clear
// engine is idle; port 1 wins same-address write collisions; cross-port
// read-during-write returns old or new data according to RDW_MODE.
//
// Ports:
//   clk              in   clock
//   rst              in   synchronous active-high reset
//   init_start       in   one-cycle pulse requesting a full clear
//   busy             out  clear engine active (also high during reset)
//   ren1/ren2        in   read request, port 1/2
//   wen1/wen2        in   write request, port 1/2
//   addr1/addr2      in   address, port 1/2
//   wdata1/wdata2    in   write data, port 1/2
//   rdata1/rdata2    out  read data, port 1/2 (zero when rvalid low)
//   rvalid1/rvalid2  out  read data qualifier, port 1/2
//   oob1/oob2        out  out-of-range access flag, port 1/2
// ---------------------------------------------------------------------------
module bmp_param_dp_ram
   import bmp_param_dp_ram_pkg::*;
#(
   parameter int                    DATA_WIDTH = `BYTE_WIDTH,
   parameter int                    ADDR_WIDTH = `ADDR_WIDTH,
   parameter int                    DEPTH      = `BMP_TOTAL_SIZE,
   parameter int                    RD_LATENCY = 1,
   parameter int                    RDW_MODE   = 0,
   parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  init_start,
   output logic                  busy,
   input  logic                  ren1,
   input  logic                  ren2,
   input  logic                  wen1,
   input  logic                  wen2,
   input  logic [ADDR_WIDTH-1:0] addr1,
   input  logic [ADDR_WIDTH-1:0] addr2,
   input  logic [DATA_WIDTH-1:0] wdata1,
   input  logic [DATA_WIDTH-1:0] wdata2,
   output logic [DATA_WIDTH-1:0] rdata1,
   output logic [DATA_WIDTH-1:0] rdata2,
   output logic                  rvalid1,
   output logic                  rvalid2,
   output logic                  oob1,
   output logic                  oob2
);

   localparam int          IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [31:0] DEPTH_U = DEPTH;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

   // Storage: never reset; contents are defined only through the clear engine.
   logic [DATA_WIDTH-1:0] mem [0:DEPTH-1];

   // Per-port views of the flat port list (index 0 = port 1, 1 = port 2).
   logic [NUM_PORTS-1:0]  ren_a, wen_a;
   logic [ADDR_WIDTH-1:0] addr_a  [NUM_PORTS];
   logic [DATA_WIDTH-1:0] wdata_a [NUM_PORTS];
   logic [DATA_WIDTH-1:0] rdata_a [NUM_PORTS];
   logic [IDX_W-1:0]      idx_a   [NUM_PORTS];
   logic [NUM_PORTS-1:0]  rvalid_a, oob_a;
   logic [NUM_PORTS-1:0]  rd_acc, wr_acc, in_range;

   // Clear engine.
   clr_state_e       state_q, state_d;
   logic [IDX_W-1:0] cnt_q, cnt_d;
   logic             busy_int;
   logic             clr_we;

   assign ren_a      = {ren2, ren1};
   assign wen_a      = {wen2, wen1};
   assign addr_a[0]  = addr1;
   assign addr_a[1]  = addr2;
   assign wdata_a[0] = wdata1;
   assign wdata_a[1] = wdata2;

   assign rdata1  = rdata_a[0];
   assign rdata2  = rdata_a[1];
   assign rvalid1 = rvalid_a[0];
   assign rvalid2 = rvalid_a[1];
   assign oob1    = oob_a[0];
   assign oob2    = oob_a[1];

   // ---------------------------------------------------------------------
   // Clear engine: one address per cycle, 0..DEPTH-1, then back to idle.
   // Reset parks the engine in CLEAR at address 0, so release starts a full
   // clear and a reset mid-clear restarts from the bottom.
   // ---------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         ST_IDLE: begin
            if (init_start) begin
               state_d = ST_CLEAR;
               cnt_d   = '0;
            end
         end
         ST_CLEAR: begin
            if (cnt_q == LAST_IDX) begin
               state_d = ST_IDLE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_CLEAR;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   assign busy_int = rst || (state_q == ST_CLEAR);
   assign busy     = busy_int;
   assign clr_we   = !rst && (state_q == ST_CLEAR);

   // ---------------------------------------------------------------------
   // Memory write. Port requests are gated by busy so they never overlap
   // the clear engine. Port 2 is applied before port 1 so that port 1 data
   // lands on a same-address collision.
   // ---------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (clr_we) begin
         mem[cnt_q] <= INIT_VALUE;
      end
      if (wr_acc[1] && in_range[1]) begin
         mem[idx_a[1]] <= wdata_a[1];
      end
      if (wr_acc[0] && in_range[0]) begin
         mem[idx_a[0]] <= wdata_a[0];
      end
   end

   // ---------------------------------------------------------------------
   // Per-port acceptance, registered read and return pipeline.
   // ---------------------------------------------------------------------
   genvar gi;
   generate
      for (gi = 0; gi < NUM_PORTS; gi++) begin : g_port
         localparam int OTHER = other_port(gi);

         logic [DATA_WIDTH-1:0] rd_word_d, rd_word_q;
         logic                  fwd_hit;

         assign in_range[gi] = {{(32 - ADDR_WIDTH){1'b0}}, addr_a[gi]} < DEPTH_U;
         assign rd_acc[gi]   = !busy_int && ren_a[gi] && !wen_a[gi];
         assign wr_acc[gi]   = !busy_int && wen_a[gi] && !ren_a[gi];
         assign idx_a[gi]    = addr_a[gi][IDX_W-1:0];

         // New-data mode: bypass the array when the other port is writing
         // the word being read in this same cycle.
         assign fwd_hit = (RDW_MODE == 1) && wr_acc[OTHER] && in_range[OTHER]
                          && (addr_a[OTHER] == addr_a[gi]);

         always_comb begin
            rd_word_d = mem[idx_a[gi]];
            if (fwd_hit) begin
               rd_word_d = wdata_a[OTHER];
            end
         end

         always_ff @(posedge clk) begin
            rd_word_q <= rd_word_d;
         end

         bmp_rd_pipe #(
            .DATA_WIDTH (DATA_WIDTH),
            .RD_LATENCY (RD_LATENCY)
         ) u_rd_pipe (
            .clk      (clk),
            .rst      (rst),
            .rd_acc   (rd_acc[gi]),
            .rd_oob   (!in_range[gi]),
            .wr_oob   (wr_acc[gi] && !in_range[gi]),
            .ram_word (rd_word_q),
            .rvalid   (rvalid_a[gi]),
            .rdata    (rdata_a[gi]),
            .oob      (oob_a[gi])
         );
      end
   endgenerate

endmodule

// File: tb/tb_bmp_param_dp_ram.sv
// ---------------------------------------------------------------------------
// tb_bmp_param_dp_ram
// Two instances share every input: dut 0 uses RD_LATENCY=1/RDW_MODE=0,
// dut 1 uses RD_LATENCY=2/RDW_MODE=1. A behavioural model (word array,
// clear countdown, per-cycle expected-output table) predicts busy, rvalid,
// rdata and oob for each instance every cycle.
// ---------------------------------------------------------------------------
module tb_bmp_param_dp_ram;

   localparam int DW    = 8;
   localparam int AW    = 5;
   localparam int DEPTH = 16;
   localparam int NSLOT = 4096;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic init_start = 1'b0;
   logic ren1 = 1'b0, ren2 = 1'b0, wen1 = 1'b0, wen2 = 1'b0;
   logic [AW-1:0] addr1 = '0, addr2 = '0;
   logic [DW-1:0] wdata1 = '0, wdata2 = '0;

   logic          busy_a, rvalid1_a, rvalid2_a, oob1_a, oob2_a;
   logic [DW-1:0] rdata1_a, rdata2_a;
   logic          busy_b, rvalid1_b, rvalid2_b, oob1_b, oob2_b;
   logic [DW-1:0] rdata1_b, rdata2_b;

   always #5 clk = ~clk;

   bmp_param_dp_ram #(
      .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH),
      .RD_LATENCY(1), .RDW_MODE(0), .INIT_VALUE(8'h00)
   ) u_dut_a (
      .clk(clk), .rst(rst), .init_start(init_start), .busy(busy_a),
      .ren1(ren1), .ren2(ren2), .wen1(wen1), .wen2(wen2),
      .addr1(addr1), .addr2(addr2), .wdata1(wdata1), .wdata2(wdata2),
      .rdata1(rdata1_a), .rdata2(rdata2_a), .rvalid1(rvalid1_a), .rvalid2(rvalid2_a),
      .oob1(oob1_a), .oob2(oob2_a)
   );

   bmp_param_dp_ram #(
      .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH),
      .RD_LATENCY(2), .RDW_MODE(1), .INIT_VALUE(8'h00)
   ) u_dut_b (
      .clk(clk), .rst(rst), .init_start(init_start), .busy(busy_b),
      .ren1(ren1), .ren2(ren2), .wen1(wen1), .wen2(wen2),
      .addr1(addr1), .addr2(addr2), .wdata1(wdata1), .wdata2(wdata2),
      .rdata1(rdata1_b), .rdata2(rdata2_b), .rvalid1(rvalid1_b), .rvalid2(rvalid2_b),
      .oob1(oob1_b), .oob2(oob2_b)
   );

   // Observed outputs indexed [dut][port].
   logic          o_busy [2];
   logic          o_rv   [2][2];
   logic          o_oob  [2][2];
   logic [DW-1:0] o_rd   [2][2];
   assign o_busy[0] = busy_a;     assign o_busy[1] = busy_b;
   assign o_rv[0][0] = rvalid1_a; assign o_rv[0][1] = rvalid2_a;
   assign o_rv[1][0] = rvalid1_b; assign o_rv[1][1] = rvalid2_b;
   assign o_oob[0][0] = oob1_a;   assign o_oob[0][1] = oob2_a;
   assign o_oob[1][0] = oob1_b;   assign o_oob[1][1] = oob2_b;
   assign o_rd[0][0] = rdata1_a;  assign o_rd[0][1] = rdata2_a;
   assign o_rd[1][0] = rdata1_b;  assign o_rd[1][1] = rdata2_b;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   // Model state.
   logic [DW-1:0] m_mem [DEPTH];
   int            clear_left = DEPTH;
   bit            e_v [2][2][NSLOT];
   bit            e_o [2][2][NSLOT];
   bit [DW-1:0]   e_d [2][2][NSLOT];
   bit            last_busy [2];

   // Command for the next cycle, indexed by port.
   bit          c_ren [2];
   bit          c_wen [2];
   int          c_addr [2];
   bit [DW-1:0] c_wdata [2];
   bit          c_init;

   function automatic int lat_of(input int d);
      return (d == 0) ? 1 : 2;
   endfunction

   task automatic chk(input string tag, input int d, input int p,
                      input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s dut%0d port%0d cyc=%0d observed=%0h expected=%0h",
                tag, d, p + 1, cyc, obs, exp);
      end
   endtask

   task automatic cmd_idle();
      for (int p = 0; p < 2; p++) begin
         c_ren[p] = 0; c_wen[p] = 0; c_addr[p] = 0; c_wdata[p] = '0;
      end
      c_init = 0;
   endtask

   task automatic cmd_rd(input int p, input int a);
      c_ren[p] = 1; c_addr[p] = a;
   endtask

   task automatic cmd_wr(input int p, input int a, input bit [DW-1:0] v);
      c_wen[p] = 1; c_addr[p] = a; c_wdata[p] = v;
   endtask

   // One clock cycle: drive command, check busy, clock, advance model,
   // check the return outputs for this cycle.
   task automatic tick();
      bit busy_m;
      bit acc_r [2];
      bit acc_w [2];
      bit inr [2];
      bit [DW-1:0] val;
      int q, s;
      @(negedge clk);
      ren1 = c_ren[0]; wen1 = c_wen[0]; addr1 = AW'(c_addr[0]); wdata1 = c_wdata[0];
      ren2 = c_ren[1]; wen2 = c_wen[1]; addr2 = AW'(c_addr[1]); wdata2 = c_wdata[1];
      init_start = c_init;
      busy_m = rst || (clear_left > 0);
      #1;
      for (int d = 0; d < 2; d++) begin
         last_busy[d] = o_busy[d];
         chk("busy", d, 0, {7'd0, o_busy[d]}, {7'd0, busy_m});
      end
      @(posedge clk);
      cyc++;
      if (cyc + 2 >= NSLOT) begin
         $display("FAIL slot_budget cyc=%0d observed=overflow expected=<%0d", cyc, NSLOT);
         $fatal(1);
      end
      if (rst) begin
         clear_left = DEPTH;
         for (int d = 0; d < 2; d++)
            for (int p = 0; p < 2; p++)
               for (int k = cyc; k <= cyc + 2; k++) begin
                  e_v[d][p][k] = 0; e_o[d][p][k] = 0; e_d[d][p][k] = '0;
               end
      end else if (clear_left > 0) begin
         m_mem[DEPTH - clear_left] = 8'h00;
         clear_left--;
      end else begin
         for (int p = 0; p < 2; p++) begin
            inr[p]   = c_addr[p] < DEPTH;
            acc_r[p] = c_ren[p] && !c_wen[p];
            acc_w[p] = c_wen[p] && !c_ren[p];
         end
         for (int p = 0; p < 2; p++) begin
            q = 1 - p;
            for (int d = 0; d < 2; d++) begin
               if (acc_r[p]) begin
                  if (!inr[p]) val = '0;
                  else if (d == 1 && acc_w[q] && inr[q] && c_addr[q] == c_addr[p]) val = c_wdata[q];
                  else val = m_mem[c_addr[p]];
                  s = cyc + lat_of(d) - 1;
                  e_v[d][p][s] = 1;
                  e_d[d][p][s] = val;
                  e_o[d][p][s] = e_o[d][p][s] | !inr[p];
               end
               if (acc_w[p] && !inr[p]) e_o[d][p][cyc] = 1;
            end
         end
         if (acc_w[1] && inr[1]) m_mem[c_addr[1]] = c_wdata[1];
         if (acc_w[0] && inr[0]) m_mem[c_addr[0]] = c_wdata[0];
         if (c_init) clear_left = DEPTH;
      end
      #1;
      for (int d = 0; d < 2; d++)
         for (int p = 0; p < 2; p++) begin
            chk("rvalid", d, p, {7'd0, o_rv[d][p]}, {7'd0, e_v[d][p][cyc]});
            chk("rdata", d, p, o_rd[d][p], e_d[d][p][cyc]);
            chk("oob", d, p, {7'd0, o_oob[d][p]}, {7'd0, e_o[d][p][cyc]});
         end
      cmd_idle();
   endtask

   // Run n cycles (with the current command repeated by the caller's loop)
   // and count busy-high cycles per instance.
   task automatic busy_window(input int n, input bit rd_during, output int cnt_a, output int cnt_b);
      cnt_a = 0; cnt_b = 0;
      for (int i = 0; i < n; i++) begin
         if (rd_during) begin
            cmd_rd(0, i % DEPTH);
            cmd_rd(1, (i + 3) % DEPTH);
         end
         tick();
         if (last_busy[0]) cnt_a++;
         if (last_busy[1]) cnt_b++;
      end
   endtask

   task automatic read_all();
      for (int a = 0; a < DEPTH; a++) begin
         cmd_rd(0, a);
         cmd_rd(1, DEPTH - 1 - a);
         tick();
      end
      tick(); tick();
   endtask

   initial begin
      int ca, cb, r;
      for (int a = 0; a < DEPTH; a++) m_mem[a] = 8'hEE;
      cmd_idle();

      // Reset, then release and time the power-up clear.
      rst = 1'b1;
      repeat (3) tick();
      rst = 1'b0;
      busy_window(20, 1'b0, ca, cb);
      chk("clear_len", 0, 0, 8'(ca), 8'd16);
      chk("clear_len", 1, 0, 8'(cb), 8'd16);
      read_all();

      // Port 1 write then port 2 read of the same word.
      cmd_wr(0, 3, 8'hA5); tick();
      cmd_rd(1, 3); tick();
      tick(); tick();

      // Same-address double write: port 1 wins.
      cmd_wr(0, 7, 8'h11); cmd_wr(1, 7, 8'h22); tick();
      cmd_rd(0, 7); tick();
      tick(); tick();

      // Cross-port read-during-write.
      cmd_wr(0, 5, 8'h33); tick();
      cmd_wr(0, 5, 8'h44); cmd_rd(1, 5); tick();
      cmd_rd(1, 5); tick();
      tick(); tick();

      // Same-port read right after write.
      cmd_wr(1, 9, 8'h5A); tick();
      cmd_rd(1, 9); tick();
      tick(); tick();

      // Out-of-range read and write; aliased word 0 must stay intact.
      cmd_rd(0, 20); cmd_wr(1, 16, 8'h77); tick();
      tick();
      cmd_rd(0, 0); tick();
      tick(); tick();

      // ren and wen together is a no-op.
      c_ren[0] = 1; c_wen[0] = 1; c_addr[0] = 2; c_wdata[0] = 8'h99; tick();
      cmd_rd(0, 2); tick();
      tick(); tick();

      // Fill with 0xFF, clear with reads in flight and reads during busy.
      for (int a = 0; a < DEPTH; a++) begin
         cmd_wr(0, a, 8'hFF); tick();
      end
      cmd_rd(0, 4); cmd_rd(1, 6); c_init = 1; tick();
      busy_window(18, 1'b1, ca, cb);
      chk("init_len", 0, 0, 8'(ca), 8'd16);
      chk("init_len", 1, 0, 8'(cb), 8'd16);
      read_all();

      // Reset in the middle of a clear restarts it from address 0.
      for (int a = 0; a < DEPTH; a++) begin
         cmd_wr(1, a, 8'(a + 8'h40)); tick();
      end
      c_init = 1; tick();
      repeat (5) tick();
      rst = 1'b1;
      repeat (2) tick();
      rst = 1'b0;
      busy_window(18, 1'b0, ca, cb);
      chk("rst_clear_len", 0, 0, 8'(ca), 8'd16);
      chk("rst_clear_len", 1, 0, 8'(cb), 8'd16);
      read_all();

      // Randomized traffic, including out-of-range, no-ops and clears.
      for (int i = 0; i < 400; i++) begin
         for (int p = 0; p < 2; p++) begin
            r = $urandom_range(0, 7);
            c_addr[p]  = (r == 7) ? 31 : $urandom_range(0, 19);
            c_wdata[p] = 8'($urandom);
            c_ren[p]   = (r inside {1, 2, 3, 6});
            c_wen[p]   = (r inside {4, 5, 6, 7});
         end
         c_init = ($urandom_range(0, 63) == 0);
         tick();
      end
      repeat (4) tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
